// File: rtl/vga_pkg.sv
// ============================================================================
// Package  : vga_pkg
// Desc     : Shared framebuffer geometry, rectangle-fill state type and
//            RGB565 colours used by the game.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int H_RES   = 320;
    localparam int V_RES   = 240;
    localparam int ADDR_W  = 17;
    localparam int DATA_W  = 16;
    localparam int COORD_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } rect_state_t;

    localparam logic [DATA_W-1:0] c_black  = 16'h0000;
    localparam logic [DATA_W-1:0] c_white  = 16'hFFFF;
    localparam logic [DATA_W-1:0] c_red    = 16'hF800;
    localparam logic [DATA_W-1:0] c_green  = 16'h07E0;
    localparam logic [DATA_W-1:0] c_blue   = 16'h001F;
    localparam logic [DATA_W-1:0] c_yellow = 16'hFFE0;

endpackage

`default_nettype wire

// File: rtl/rect_addr_gen.sv
// ============================================================================
// Module   : rect_addr_gen
// Desc     : Row-major pixel address walker for a clipped rectangle; keeps a
//            running row base so no per-pixel multiply is needed.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rect_addr_gen #(
    parameter int H_RES   = 320,
    parameter int ADDR_W  = 17,
    parameter int COORD_W = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               advance,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W:0]   xe,
    input  logic [COORD_W:0]   ye,
    output logic [ADDR_W-1:0]  address,
    output logic               last
);

    logic [COORD_W-1:0] r_col;
    logic [COORD_W-1:0] r_row;
    logic [COORD_W-1:0] r_xs;
    logic [COORD_W:0]   r_xe;
    logic [COORD_W:0]   r_ye;
    logic [ADDR_W-1:0]  r_row_base;

    logic [COORD_W:0]   w_col_inc;
    logic [COORD_W:0]   w_row_inc;
    logic               w_col_more;
    logic               w_row_more;

    assign w_col_inc  = {1'b0, r_col} + 1'b1;
    assign w_row_inc  = {1'b0, r_row} + 1'b1;
    assign w_col_more = (w_col_inc < r_xe);
    assign w_row_more = (w_row_inc < r_ye);

    assign address = r_row_base + ADDR_W'(r_col);
    assign last    = !w_col_more && !w_row_more;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_col      <= '0;
            r_row      <= '0;
            r_xs       <= '0;
            r_xe       <= '0;
            r_ye       <= '0;
            r_row_base <= '0;
        end else if (load) begin
            r_col      <= x0;
            r_row      <= y0;
            r_xs       <= x0;
            r_xe       <= xe;
            r_ye       <= ye;
            // The only multiply: once per command, never per pixel.
            r_row_base <= ADDR_W'(y0) * ADDR_W'(H_RES);
        end else if (advance) begin
            if (w_col_more) begin
                r_col <= w_col_inc[COORD_W-1:0];
            end else if (w_row_more) begin
                r_col      <= r_xs;
                r_row      <= w_row_inc[COORD_W-1:0];
                r_row_base <= r_row_base + ADDR_W'(H_RES);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rect_fill_master.sv
// ============================================================================
// Module   : rect_fill_master
// Desc     : Avalon-MM write master filling a screen-clipped rectangle of the
//            RGB565 framebuffer with a single colour, one pixel per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rect_fill_master #(
    parameter int H_RES   = vga_pkg::H_RES,
    parameter int V_RES   = vga_pkg::V_RES,
    parameter int ADDR_W  = vga_pkg::ADDR_W,
    parameter int DATA_W  = vga_pkg::DATA_W,
    parameter int COORD_W = vga_pkg::COORD_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] w,
    input  logic [COORD_W-1:0] h,
    input  logic [DATA_W-1:0]  colour,
    output logic               busy,
    output logic               done,
    output logic               chipselect,
    output logic               write,
    output logic [ADDR_W-1:0]  address,
    output logic [DATA_W-1:0]  writedata,
    input  logic               waitrequest
);

    import vga_pkg::*;

    if (H_RES * V_RES > 2 ** ADDR_W) begin : g_size_check
        $error("rect_fill_master: framebuffer does not fit in ADDR_W address bits");
    end

    localparam logic [COORD_W:0] c_h_lim = (COORD_W+1)'(H_RES);
    localparam logic [COORD_W:0] c_v_lim = (COORD_W+1)'(V_RES);

    rect_state_t        r_state;
    rect_state_t        w_state_nxt;

    logic [COORD_W-1:0] r_x0;
    logic [COORD_W-1:0] r_y0;
    logic [COORD_W-1:0] r_w;
    logic [COORD_W-1:0] r_h;
    logic [DATA_W-1:0]  r_colour;

    logic [COORD_W:0]   w_xsum;
    logic [COORD_W:0]   w_ysum;
    logic [COORD_W:0]   w_xe;
    logic [COORD_W:0]   w_ye;
    logic               w_empty;
    logic               w_load;
    logic               w_advance;
    logic               w_last;
    logic [ADDR_W-1:0]  w_pix_addr;

    // One extra bit keeps x0+w / y0+h from wrapping before the clip.
    assign w_xsum  = {1'b0, r_x0} + {1'b0, r_w};
    assign w_ysum  = {1'b0, r_y0} + {1'b0, r_h};
    assign w_xe    = (w_xsum > c_h_lim) ? c_h_lim : w_xsum;
    assign w_ye    = (w_ysum > c_v_lim) ? c_v_lim : w_ysum;
    assign w_empty = (r_w == '0) || (r_h == '0) ||
                     ({1'b0, r_x0} >= c_h_lim) || ({1'b0, r_y0} >= c_v_lim);

    assign w_load    = (r_state == SETUP) && !w_empty;
    assign w_advance = (r_state == WRITE) && !waitrequest;

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_x0     <= '0;
            r_y0     <= '0;
            r_w      <= '0;
            r_h      <= '0;
            r_colour <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_x0     <= x0;
            r_y0     <= y0;
            r_w      <= w;
            r_h      <= h;
            r_colour <= colour;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        chipselect  = 1'b0;
        write       = 1'b0;
        address     = '0;
        writedata   = '0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                w_state_nxt = w_empty ? DONE : WRITE;
            end
            WRITE: begin
                // Bus fields come from registers, so they stay put under waitrequest.
                chipselect = 1'b1;
                write      = 1'b1;
                address    = w_pix_addr;
                writedata  = r_colour;
                if (!waitrequest && w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    rect_addr_gen #(
        .H_RES   (H_RES),
        .ADDR_W  (ADDR_W),
        .COORD_W (COORD_W)
    ) u_addr_gen (
        .clock   (clock),
        .reset   (reset),
        .load    (w_load),
        .advance (w_advance),
        .x0      (r_x0),
        .y0      (r_y0),
        .xe      (w_xe),
        .ye      (w_ye),
        .address (w_pix_addr),
        .last    (w_last)
    );

endmodule

`default_nettype wire

// File: tb/tb_rect_fill_master.sv
// ============================================================================
// Module   : tb_rect_fill_master
// Desc     : Scoreboard bench for rect_fill_master with directed and random
//            rectangle commands against a loop-based reference of the fill.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rect_fill_master;

    typedef struct packed {
        logic [16:0] a;
        logic [15:0] d;
    } pix_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  x0, y0, w, h;
    logic [15:0] colour;
    logic        busy, done, chipselect, write;
    logic [16:0] address;
    logic [15:0] writedata;
    logic        waitrequest = 1'b0;

    int   total = 0;
    int   bad   = 0;
    int   acc_cnt  = 0;
    int   done_cnt = 0;
    int   wr_mode  = 0;
    int   stall_idx  = -1;
    int   stall_left = 0;

    pix_t exp_q[$];
    pix_t e;
    logic        held_valid = 1'b0;
    logic [16:0] held_addr;
    logic [15:0] held_data;

    rect_fill_master dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .x0          (x0),
        .y0          (y0),
        .w           (w),
        .h           (h),
        .colour      (colour),
        .busy        (busy),
        .done        (done),
        .chipselect  (chipselect),
        .write       (write),
        .address     (address),
        .writedata   (writedata),
        .waitrequest (waitrequest)
    );

    always #5 clock = ~clock;

    // Slave model: waitrequest updated just after each rising edge.
    always @(posedge clock) begin
        #1;
        if (wr_mode == 1) begin
            waitrequest = ($urandom_range(0, 3) == 0);
        end else if (wr_mode == 2 && write && acc_cnt == stall_idx && stall_left > 0) begin
            waitrequest = 1'b1;
            stall_left  = stall_left - 1;
        end else begin
            waitrequest = 1'b0;
        end
    end

    // Monitor: pops the scoreboard on every accepted write.
    always @(negedge clock) begin
        if (reset) begin
            held_valid = 1'b0;
        end else begin
            if (held_valid) begin
                total++;
                if (!(write === 1'b1 && address === held_addr && writedata === held_data)) begin
                    bad++;
                    $display("FAIL hold: got write=%0b addr=%0d data=%h, need write=1 addr=%0d data=%h",
                             write, address, writedata, held_addr, held_data);
                end
            end
            if (write || chipselect) begin
                total++;
                if (!(write && chipselect)) begin
                    bad++;
                    $display("FAIL strobe: got cs=%0b write=%0b, need both 1", chipselect, write);
                end
                if (!waitrequest) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL extra_write: got addr=%0d data=%h, need no write", address, writedata);
                    end else begin
                        e = exp_q.pop_front();
                        if (address !== e.a || writedata !== e.d) begin
                            bad++;
                            $display("FAIL pixel: got addr=%0d data=%h, need addr=%0d data=%h",
                                     address, writedata, e.a, e.d);
                        end
                    end
                    acc_cnt++;
                end
            end else begin
                total++;
                if (address !== 17'd0 || writedata !== 16'd0) begin
                    bad++;
                    $display("FAIL idle_bus: got addr=%0d data=%h, need 0/0", address, writedata);
                end
            end
            if (done) done_cnt++;
            held_valid = write && waitrequest;
            held_addr  = address;
            held_data  = writedata;
        end
    end

    // Reference: every on-screen pixel of the rectangle, row-major.
    task automatic model_push(input int cx, input int cy, input int cw, input int ch,
                              input logic [15:0] c, output int n);
        pix_t p;
        n = 0;
        for (int y = cy; y < cy + ch && y < 240; y++) begin
            for (int x = cx; x < cx + cw && x < 320; x++) begin
                p.a = 17'(y * 320 + x);
                p.d = c;
                exp_q.push_back(p);
                n++;
            end
        end
    endtask

    task automatic check(input string name, input int got, input int need);
        total++;
        if (got != need) begin
            bad++;
            $display("FAIL %s: got %0d, need %0d", name, got, need);
        end
    endtask

    // Issues one command; start is sampled at "edge 0", cycle c follows edge c-1.
    task automatic run_cmd(input string name, input int cx, input int cy, input int cw, input int ch,
                           input logic [15:0] c, input int mode, input int st_off, input int st_len,
                           input int restart_at, input int exp_done);
        int  n, cyc, stalls, d0;
        bit  seen;
        model_push(cx, cy, cw, ch, c, n);
        stalls     = 0;
        seen       = 0;
        cyc        = 0;
        d0         = done_cnt;
        stall_idx  = acc_cnt + st_off;
        stall_left = st_len;
        wr_mode    = mode;
        @(negedge clock);
        x0 = 10'(cx); y0 = 10'(cy); w = 10'(cw); h = 10'(ch); colour = c;
        start = 1'b1;
        @(posedge clock);
        for (int k = 1; k <= 2000 && !seen; k++) begin
            @(negedge clock);
            cyc = k;
            if (k == 1) start = 1'b0;
            if (restart_at > 0 && k == restart_at) begin
                x0 = 10'd0; y0 = 10'd0; w = 10'd9; h = 10'd9; colour = ~c;
                start = 1'b1;
            end
            if (restart_at > 0 && k == restart_at + 1) start = 1'b0;
            check({name, "_busy"}, int'(busy), 1);
            if (write && waitrequest) stalls++;
            if (done) seen = 1;
        end
        if (!seen) begin
            bad++;
            total++;
            $display("FAIL %s_timeout: got no done, need done within 2000 cycles", name);
        end else begin
            check({name, "_done_cycle"}, cyc, (exp_done >= 0) ? exp_done : 2 + n + stalls);
        end
        @(negedge clock);
        check({name, "_done_width"}, int'(done), 0);
        check({name, "_idle_busy"}, int'(busy), 0);
        check({name, "_missing_writes"}, exp_q.size(), 0);
        check({name, "_done_pulses"}, done_cnt - d0, 1);
        exp_q.delete();
        wr_mode = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, need finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, d0;
        bit hit;
        start = 1'b0; x0 = '0; y0 = '0; w = '0; h = '0; colour = '0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_cs", int'(chipselect), 0);
        check("rst_write", int'(write), 0);
        check("rst_addr", int'(address), 0);
        check("rst_data", int'(writedata), 0);
        reset = 1'b0;
        @(negedge clock);

        run_cmd("basic",   10,  5, 2, 2, 16'hF800, 0, 0, 0, 0, 6);
        run_cmd("stall",   10,  5, 2, 2, 16'hF800, 2, 1, 3, 0, 9);
        run_cmd("clip",   318, 239, 4, 3, 16'h07E0, 0, 0, 0, 0, 4);
        run_cmd("offx",   320,  10, 5, 2, 16'h001F, 0, 0, 0, 0, 2);
        run_cmd("empty_w", 20,  20, 0, 7, 16'hFFFF, 0, 0, 0, 0, 2);
        run_cmd("empty_h", 20,  20, 5, 0, 16'hFFFF, 0, 0, 0, 0, 2);
        run_cmd("restart",100, 100, 2, 2, 16'hFFE0, 0, 0, 0, 3, 6);

        // Reset while the third pixel is stalled.
        model_push(0, 0, 5, 1, 16'h1234, base);
        base       = acc_cnt;
        stall_idx  = acc_cnt + 2;
        stall_left = 20;
        wr_mode    = 2;
        @(negedge clock);
        x0 = 10'd0; y0 = 10'd0; w = 10'd5; h = 10'd1; colour = 16'h1234;
        start = 1'b1;
        @(posedge clock);
        hit = 0;
        for (int k = 1; k <= 60 && !hit; k++) begin
            @(negedge clock);
            start = 1'b0;
            if (write && waitrequest && acc_cnt == base + 2) hit = 1;
        end
        check("rst_mid_reached", int'(hit), 1);
        #2;
        reset   = 1'b1;
        wr_mode = 0;
        #1;
        check("rst_mid_write", int'(write), 0);
        check("rst_mid_cs", int'(chipselect), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_done", int'(done), 0);
        exp_q.delete();
        d0 = done_cnt;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_mid_no_done", done_cnt - d0, 0);
        check("rst_mid_idle", int'(busy), 0);
        run_cmd("after_rst", 0, 0, 1, 1, 16'hABCD, 0, 0, 0, 0, 3);

        for (int i = 0; i < 25; i++) begin
            run_cmd("rand", int'($urandom_range(0, 330)), int'($urandom_range(0, 250)),
                    int'($urandom_range(0, 12)), int'($urandom_range(0, 6)),
                    16'($urandom), int'($urandom_range(0, 1)), 0, 0, 0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
